// File: rtl/loopback_err_checker_pkg.sv
// rtl/loopback_err_checker_pkg.sv - shared state type, default widths and thresholds for the loopback checker
package loopback_chk_pkg;

    typedef enum logic {
        SEARCH = 1'b0,
        LOCKED = 1'b1
    } lb_state_e;

    localparam int DEF_DATA_W        = 32;
    localparam int DEF_CNT_W         = 32;
    localparam int DEF_LOSS_W        = 16;
    localparam int DEF_LOCK_THRESH   = 4;
    localparam int DEF_UNLOCK_THRESH = 8;

endpackage

// File: rtl/loopback_err_checker_if.sv
// rtl/loopback_err_checker_if.sv - received loopback word stream (valid + data)
interface loopback_err_checker_if
    import loopback_chk_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) ();

    logic              rx_valid;
    logic [DATA_W-1:0] rx_data;

    modport master (output rx_valid, output rx_data);
    modport slave  (input  rx_valid, input  rx_data);

endinterface

// File: rtl/loopback_err_checker_sat_counter.sv
// rtl/loopback_err_checker_sat_counter.sv - generic event counter with clear and saturate-or-wrap mode
module lb_sat_counter #(
    parameter int W   = 32,
    parameter bit SAT = 1'b0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    // Clear beats a coincident increment; in SAT mode the count parks at all-ones.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (inc && !(SAT && (&cnt))) begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/loopback_err_checker.sv
// rtl/loopback_err_checker.sv - incrementing-pattern loopback checker; LB_ERR_CNT_SAT_EN makes err_cnt saturate
module loopback_err_checker
    import loopback_chk_pkg::*;
#(
    parameter int DATA_W        = DEF_DATA_W,
    parameter int CNT_W         = DEF_CNT_W,
    parameter int LOCK_THRESH   = DEF_LOCK_THRESH,
    parameter int UNLOCK_THRESH = DEF_UNLOCK_THRESH,
    parameter int LOSS_W        = DEF_LOSS_W
) (
    input  logic                   user_clk,
    input  logic                   user_rst,
    loopback_err_checker_if.slave  rx,
    input  logic                   cnt_clr,
    output logic [CNT_W-1:0]       err_cnt,
    output logic                   locked,
    output logic [LOSS_W-1:0]      lock_loss_cnt,
    output logic                   err_pulse
);

    localparam int MR_W = $clog2(LOCK_THRESH + 1);
    localparam int BR_W = $clog2(UNLOCK_THRESH + 1);
    localparam logic [MR_W-1:0] LOCK_T   = MR_W'(LOCK_THRESH);
    localparam logic [BR_W-1:0] UNLOCK_T = BR_W'(UNLOCK_THRESH);

`ifdef LB_ERR_CNT_SAT_EN
    localparam bit ERR_SAT = 1'b1;
`else
    localparam bit ERR_SAT = 1'b0;
`endif

    lb_state_e         state_q, state_d;
    logic [DATA_W-1:0] exp_q, exp_d;
    logic [MR_W-1:0]   match_run_q, match_run_d;
    logic [BR_W-1:0]   bad_run_q, bad_run_d;
    logic              err_inc;
    logic              loss_inc;

    // Next-state logic: SEARCH re-seeds from the stream, LOCKED free-runs its own sequence.
    always_comb begin
        state_d     = state_q;
        exp_d       = exp_q;
        match_run_d = match_run_q;
        bad_run_d   = bad_run_q;
        err_inc     = 1'b0;
        loss_inc    = 1'b0;
        if (rx.rx_valid) begin
            case (state_q)
                SEARCH: begin
                    exp_d = rx.rx_data + DATA_W'(1);
                    if ((rx.rx_data == exp_q) && (match_run_q != '0)) begin
                        match_run_d = match_run_q + MR_W'(1);
                    end else begin
                        match_run_d = MR_W'(1);
                    end
                    if (match_run_d == LOCK_T) begin
                        state_d   = LOCKED;
                        bad_run_d = '0;
                    end
                end
                LOCKED: begin
                    exp_d = exp_q + DATA_W'(1);
                    if (rx.rx_data == exp_q) begin
                        bad_run_d = '0;
                    end else begin
                        err_inc   = 1'b1;
                        bad_run_d = bad_run_q + BR_W'(1);
                        if (bad_run_d == UNLOCK_T) begin
                            state_d     = SEARCH;
                            match_run_d = '0;
                            loss_inc    = 1'b1;
                        end
                    end
                end
                default: state_d = SEARCH;
            endcase
        end
    end

    // State, pattern tracker and run counters; the error strobe is a registered copy of err_inc.
    always_ff @(posedge user_clk) begin
        if (user_rst) begin
            state_q     <= SEARCH;
            exp_q       <= '0;
            match_run_q <= '0;
            bad_run_q   <= '0;
            err_pulse   <= 1'b0;
        end else begin
            state_q     <= state_d;
            exp_q       <= exp_d;
            match_run_q <= match_run_d;
            bad_run_q   <= bad_run_d;
            err_pulse   <= err_inc;
        end
    end

    assign locked = (state_q == LOCKED);

    lb_sat_counter #(
        .W   (CNT_W),
        .SAT (ERR_SAT)
    ) u_err_cnt (
        .clk (user_clk),
        .rst (user_rst),
        .clr (cnt_clr),
        .inc (err_inc),
        .cnt (err_cnt)
    );

    lb_sat_counter #(
        .W   (LOSS_W),
        .SAT (1'b1)
    ) u_loss_cnt (
        .clk (user_clk),
        .rst (user_rst),
        .clr (cnt_clr),
        .inc (loss_inc),
        .cnt (lock_loss_cnt)
    );

endmodule

// File: tb/tb_loopback_err_checker.sv
// tb/tb_loopback_err_checker.sv - directed and randomized checks of loopback_err_checker against a reference model
module tb_loopback_err_checker;

    localparam int LOCK_THRESH   = 4;
    localparam int UNLOCK_THRESH = 8;

    logic clk = 1'b0;
    logic rst;
    logic cnt_clr;

    logic [31:0] err_cnt;
    logic        locked;
    logic [15:0] lock_loss_cnt;
    logic        err_pulse;

    logic [3:0]  err_cnt_n;
    logic        locked_n;
    logic [1:0]  lock_loss_cnt_n;
    logic        err_pulse_n;

    int n_total = 0;
    int n_bad   = 0;
    int pulses  = 0;

    bit          m_locked;
    logic [31:0] m_exp;
    int          m_match;
    int          m_bad;
    longint      m_err;
    int          m_loss;
    bit          m_pulse;

    always #5 clk = ~clk;

    loopback_err_checker_if #(.DATA_W(32)) rx_if ();

    loopback_err_checker dut (
        .user_clk      (clk),
        .user_rst      (rst),
        .rx            (rx_if.slave),
        .cnt_clr       (cnt_clr),
        .err_cnt       (err_cnt),
        .locked        (locked),
        .lock_loss_cnt (lock_loss_cnt),
        .err_pulse     (err_pulse)
    );

    loopback_err_checker #(
        .CNT_W  (4),
        .LOSS_W (2)
    ) dut_n (
        .user_clk      (clk),
        .user_rst      (rst),
        .rx            (rx_if.slave),
        .cnt_clr       (cnt_clr),
        .err_cnt       (err_cnt_n),
        .locked        (locked_n),
        .lock_loss_cnt (lock_loss_cnt_n),
        .err_pulse     (err_pulse_n)
    );

    function automatic longint cnt_view(input longint total, input int w);
        longint top;
        top = (longint'(1) << w) - 1;
`ifdef LB_ERR_CNT_SAT_EN
        return (total > top) ? top : total;
`else
        return total & top;
`endif
    endfunction

    function automatic longint sat_view(input longint total, input int w);
        longint top;
        top = (longint'(1) << w) - 1;
        return (total > top) ? top : total;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_total++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic model(input bit r, input bit v, input logic [31:0] d, input bit c);
        if (r) begin
            m_locked = 0; m_exp = '0; m_match = 0; m_bad = 0;
            m_err = 0; m_loss = 0; m_pulse = 0;
        end else begin
            m_pulse = 0;
            if (v) begin
                if (!m_locked) begin
                    m_match = (d == m_exp && m_match != 0) ? m_match + 1 : 1;
                    m_exp   = d + 32'd1;
                    if (m_match == LOCK_THRESH) begin
                        m_locked = 1;
                        m_bad    = 0;
                    end
                end else begin
                    if (d == m_exp) begin
                        m_bad = 0;
                    end else begin
                        m_err++;
                        m_pulse = 1;
                        m_bad++;
                        if (m_bad == UNLOCK_THRESH) begin
                            m_locked = 0;
                            m_match  = 0;
                            m_loss++;
                        end
                    end
                    m_exp = m_exp + 32'd1;
                end
            end
            if (c) begin
                m_err  = 0;
                m_loss = 0;
            end
        end
    endtask

    task automatic step(input bit r, input bit v, input logic [31:0] d, input bit c);
        rst             = r;
        rx_if.rx_valid  = v;
        rx_if.rx_data   = d;
        cnt_clr         = c;
        @(posedge clk);
        model(r, v, d, c);
        @(negedge clk);
        if (err_pulse) pulses++;
        chk("err_cnt",         64'(err_cnt),         64'(cnt_view(m_err, 32)));
        chk("err_cnt_n",       64'(err_cnt_n),       64'(cnt_view(m_err, 4)));
        chk("locked",          64'(locked),          64'(m_locked));
        chk("locked_n",        64'(locked_n),        64'(m_locked));
        chk("lock_loss_cnt",   64'(lock_loss_cnt),   64'(sat_view(m_loss, 16)));
        chk("lock_loss_cnt_n", 64'(lock_loss_cnt_n), 64'(sat_view(m_loss, 2)));
        chk("err_pulse",       64'(err_pulse),       64'(m_pulse));
        chk("err_pulse_n",     64'(err_pulse_n),     64'(m_pulse));
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(0, 0, 32'h0, 0);
    endtask

    initial begin
        logic [31:0] rd;
        logic [31:0] wrap_start;
        int          sel;
        bit          r, v, c;
        int          want_n;

        rst = 1'b1; cnt_clr = 1'b0; rx_if.rx_valid = 1'b0; rx_if.rx_data = '0;
        model(1, 0, 0, 0);
        @(negedge clk);

        step(1, 0, 32'h0, 0);
        step(1, 1, 32'h55, 1);
        chk("reset_err_cnt", 64'(err_cnt), 64'd0);
        chk("reset_locked",  64'(locked),  64'd0);

        // lock on 100..103
        for (int i = 0; i < 4; i++) step(0, 1, 32'd100 + 32'(i), 0);
        chk("lock_after_103", 64'(locked), 64'd1);
        chk("lock_err_cnt",   64'(err_cnt), 64'd0);

        // two bad words while locked
        pulses = 0;
        step(0, 1, 32'd104, 0);
        step(0, 1, 32'hDEAD, 0);
        step(0, 1, 32'd106, 0);
        step(0, 1, 32'hBEEF, 0);
        step(0, 1, 32'd108, 0);
        chk("errors_err_cnt", 64'(err_cnt), 64'd2);
        chk("errors_pulses",  64'(pulses),  64'd2);
        chk("errors_locked",  64'(locked),  64'd1);

        // clear, then eight wrong words force unlock
        step(0, 0, 32'h0, 1);
        for (int i = 0; i < 8; i++) step(0, 1, 32'hAAAA0000 + 32'(i), 0);
        chk("unlock_locked",  64'(locked),        64'd0);
        chk("unlock_err_cnt", 64'(err_cnt),       64'd8);
        chk("unlock_loss",    64'(lock_loss_cnt), 64'd1);
        for (int i = 0; i < 4; i++) step(0, 1, 32'd500 + 32'(i), 0);
        chk("relock_locked",  64'(locked), 64'd1);

        // lock across the 2^32 wrap with idle gaps
        step(1, 0, 32'h0, 0);
        wrap_start = 32'hFFFFFFFD;
        for (int i = 0; i < 6; i++) begin
            step(0, 1, wrap_start + 32'(i), 0);
            idle(3);
        end
        chk("wrap_locked",  64'(locked),  64'd1);
        chk("wrap_err_cnt", 64'(err_cnt), 64'd0);

        // clear colliding with a counted error
        for (int i = 0; i < 5; i++) step(0, 1, 32'hC0DE0000 + 32'(i), 0);
        chk("pre_clr_err_cnt", 64'(err_cnt), 64'd5);
        step(0, 1, m_exp, 0);
        step(0, 1, 32'h12345678, 1);
        chk("clr_coll_err_cnt", 64'(err_cnt),   64'd0);
        chk("clr_coll_pulse",   64'(err_pulse), 64'd1);
        chk("clr_coll_locked",  64'(locked),    64'd1);

        // twenty errors without losing lock
        step(1, 0, 32'h0, 0);
        for (int i = 0; i < 4; i++) step(0, 1, 32'(i), 0);
        for (int i = 0; i < 20; i++) begin
            step(0, 1, ~m_exp, 0);
            if (i % 4 == 3) step(0, 1, m_exp, 0);
        end
`ifdef LB_ERR_CNT_SAT_EN
        want_n = 15;
`else
        want_n = 4;
`endif
        chk("sat_err_cnt_n", 64'(err_cnt_n), 64'(want_n));
        chk("sat_err_cnt",   64'(err_cnt),   64'd20);
        chk("sat_locked",    64'(locked),    64'd1);

        // randomized traffic with error bursts, clears and resets
        for (int i = 0; i < 500; i++) begin
            if (i % 60 == 30) begin
                for (int k = 0; k < 9; k++) step(0, 1, ~m_exp, 0);
            end
            r   = ($urandom_range(0, 199) == 0);
            v   = ($urandom_range(0, 3) != 0);
            c   = ($urandom_range(0, 39) == 0);
            sel = $urandom_range(0, 9);
            rd  = (sel < 7) ? m_exp : $urandom;
            step(r, v, rd, c);
        end

        // reset and clear together
        step(1, 1, 32'h1, 1);
        chk("rst_clr_err_cnt", 64'(err_cnt), 64'd0);
        chk("rst_clr_locked",  64'(locked),  64'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
